// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle between the EX-stage control and the
// multi-cycle ALU, parametrised by operand width.
interface alu_mc_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [3:0]       control;
    logic [WIDTH-1:0] input_a;
    logic [WIDTH-1:0] input_b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cout;
    logic             err_overflow;
    logic             err_invalid_control;
    logic             err_div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, control, input_a, input_b,
        input  ready, done, result, zero, cout, err_overflow,
               err_invalid_control, err_div_zero, hi, lo
    );

    modport slave (
        input  start, control, input_a, input_b,
        output ready, done, result, zero, cout, err_overflow,
               err_invalid_control, err_div_zero, hi, lo
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: MIPS EX-stage ALU. Logic/add/sub/compare complete in one clock;
// MULTU (shift-add) and DIVU (restoring) iterate one bit per clock into HI/LO.
module alu_mc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic    clock,
    input  logic    reset,
    alu_mc_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND   = 4'h0;
    localparam logic [3:0] OP_OR    = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_ADDU  = 4'h3;
    localparam logic [3:0] OP_SLTU  = 4'h4;
    localparam logic [3:0] OP_SUB   = 4'h6;
    localparam logic [3:0] OP_SLT   = 4'h7;
    localparam logic [3:0] OP_MULTU = 4'h8;
    localparam logic [3:0] OP_DIVU  = 4'h9;
    localparam logic [3:0] OP_MFHI  = 4'hA;
    localparam logic [3:0] OP_MFLO  = 4'hB;
    localparam logic [3:0] OP_NOR   = 4'hC;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_opd, w_opd_nxt;
    logic [WIDTH-1:0] r_ph, w_ph_nxt;
    logic [WIDTH-1:0] r_pl, w_pl_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic [WIDTH-1:0] r_hi, w_hi_nxt;
    logic [WIDTH-1:0] r_lo, w_lo_nxt;
    logic             r_cout, w_cout_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic             r_inv, w_inv_nxt;
    logic             r_dz, w_dz_nxt;
    logic             r_done, w_done_nxt;
    logic             r_ready, w_ready_nxt;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH:0]   w_div_sh;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_diff;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quo;
    logic             w_last;
    logic             w_a_msb;
    logic             w_b_msb;

    assign w_a_msb = bus.input_a[WIDTH-1];
    assign w_b_msb = bus.input_b[WIDTH-1];
    assign w_add   = {1'b0, bus.input_a} + {1'b0, bus.input_b};
    assign w_sub   = {1'b0, bus.input_a} + {1'b0, ~bus.input_b} + (WIDTH+1)'(1);

    // Multiply step: {ph,pl} holds partial product over the unconsumed multiplier bits.
    assign w_mul_sum = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_opd} : '0);
    assign w_mul_hi  = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_pl[WIDTH-1:1]};

    // Divide step: ph is the partial remainder, pl shifts dividend out / quotient in.
    assign w_div_sh   = {r_ph, r_pl[WIDTH-1]};
    assign w_div_ge   = (w_div_sh >= {1'b0, r_opd});
    assign w_div_diff = w_div_sh[WIDTH-1:0] - r_opd;
    assign w_div_rem  = w_div_ge ? w_div_diff : w_div_sh[WIDTH-1:0];
    assign w_div_quo  = {r_pl[WIDTH-2:0], w_div_ge};

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_opd    <= '0;
            r_ph     <= '0;
            r_pl     <= '0;
            r_result <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_inv    <= 1'b0;
            r_dz     <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_opd    <= w_opd_nxt;
            r_ph     <= w_ph_nxt;
            r_pl     <= w_pl_nxt;
            r_result <= w_result_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_cout   <= w_cout_nxt;
            r_ovf    <= w_ovf_nxt;
            r_inv    <= w_inv_nxt;
            r_dz     <= w_dz_nxt;
            r_done   <= w_done_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_opd_nxt    = r_opd;
        w_ph_nxt     = r_ph;
        w_pl_nxt     = r_pl;
        w_result_nxt = r_result;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_cout_nxt   = r_cout;
        w_ovf_nxt    = r_ovf;
        w_inv_nxt    = r_inv;
        w_dz_nxt     = r_dz;
        w_done_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_cout_nxt = 1'b0;
                    w_ovf_nxt  = 1'b0;
                    w_inv_nxt  = 1'b0;
                    w_dz_nxt   = 1'b0;
                    w_done_nxt = 1'b1;
                    case (bus.control)
                        OP_AND:  w_result_nxt = bus.input_a & bus.input_b;
                        OP_OR:   w_result_nxt = bus.input_a | bus.input_b;
                        OP_NOR:  w_result_nxt = ~(bus.input_a | bus.input_b);
                        OP_ADD: begin
                            w_result_nxt = w_add[WIDTH-1:0];
                            w_cout_nxt   = w_add[WIDTH];
                            w_ovf_nxt    = (w_a_msb == w_b_msb) && (w_add[WIDTH-1] != w_a_msb);
                        end
                        OP_ADDU: begin
                            w_result_nxt = w_add[WIDTH-1:0];
                            w_cout_nxt   = w_add[WIDTH];
                            w_ovf_nxt    = w_add[WIDTH];
                        end
                        OP_SUB: begin
                            w_result_nxt = w_sub[WIDTH-1:0];
                            w_cout_nxt   = w_sub[WIDTH];
                            w_ovf_nxt    = (w_a_msb != w_b_msb) && (w_sub[WIDTH-1] != w_a_msb);
                        end
                        OP_SLT:  w_result_nxt = WIDTH'($signed(bus.input_a) < $signed(bus.input_b));
                        OP_SLTU: w_result_nxt = WIDTH'(bus.input_a < bus.input_b);
                        OP_MFHI: w_result_nxt = r_hi;
                        OP_MFLO: w_result_nxt = r_lo;
                        OP_MULTU: begin
                            w_done_nxt  = 1'b0;
                            w_state_nxt = S_MUL;
                            w_cnt_nxt   = '0;
                            w_opd_nxt   = bus.input_a;
                            w_ph_nxt    = '0;
                            w_pl_nxt    = bus.input_b;
                        end
                        OP_DIVU: begin
                            if (bus.input_b == '0) begin
                                w_dz_nxt = 1'b1;
                            end else begin
                                w_done_nxt  = 1'b0;
                                w_state_nxt = S_DIV;
                                w_cnt_nxt   = '0;
                                w_opd_nxt   = bus.input_b;
                                w_ph_nxt    = '0;
                                w_pl_nxt    = bus.input_a;
                            end
                        end
                        default: w_inv_nxt = 1'b1;
                    endcase
                end
            end
            S_MUL: begin
                w_ph_nxt  = w_mul_hi;
                w_pl_nxt  = w_mul_lo;
                w_cnt_nxt = r_cnt + CW'(1);
                if (w_last) begin
                    w_state_nxt  = S_IDLE;
                    w_cnt_nxt    = '0;
                    w_hi_nxt     = w_mul_hi;
                    w_lo_nxt     = w_mul_lo;
                    w_result_nxt = w_mul_lo;
                    w_done_nxt   = 1'b1;
                end
            end
            S_DIV: begin
                w_ph_nxt  = w_div_rem;
                w_pl_nxt  = w_div_quo;
                w_cnt_nxt = r_cnt + CW'(1);
                if (w_last) begin
                    w_state_nxt  = S_IDLE;
                    w_cnt_nxt    = '0;
                    w_hi_nxt     = w_div_rem;
                    w_lo_nxt     = w_div_quo;
                    w_result_nxt = w_div_quo;
                    w_done_nxt   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_ready_nxt = (w_state_nxt == S_IDLE);
    end

    assign bus.ready               = r_ready;
    assign bus.done                = r_done;
    assign bus.result              = r_result;
    assign bus.zero                = (r_result == '0);
    assign bus.cout                = r_cout;
    assign bus.err_overflow        = r_ovf;
    assign bus.err_invalid_control = r_inv;
    assign bus.err_div_zero        = r_dz;
    assign bus.hi                  = r_hi;
    assign bus.lo                  = r_lo;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: randomized and directed checks of alu_mc (WIDTH 32 and 8) against
// an arithmetic reference model of the ALU's architectural state.
module tb_alu_mc;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(32)) bus32 ();
    alu_mc_if #(.WIDTH(8))  bus8 ();

    alu_mc #(.WIDTH(32)) dut32 (.clock(clk), .reset(rst), .bus(bus32));
    alu_mc #(.WIDTH(8))  dut8  (.clock(clk), .reset(rst), .bus(bus8));

    int checks = 0;
    int errors = 0;

    // Reference architectural state and expected flags
    logic [31:0] m_res, m_hi, m_lo;
    logic        e_cout, e_ovf, e_inv, e_dz;

    function automatic logic [102:0] snap32();
        return {bus32.result, bus32.hi, bus32.lo, bus32.cout, bus32.err_overflow,
                bus32.err_invalid_control, bus32.err_div_zero, bus32.done,
                bus32.ready, bus32.zero};
    endfunction

    function automatic logic [102:0] want32(input logic done, input logic ready);
        return {m_res, m_hi, m_lo, e_cout, e_ovf, e_inv, e_dz, done, ready, (m_res == 32'd0)};
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return 32'($urandom());
        endcase
    endfunction

    // Behavioural model: architectural effect of one accepted operation
    task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint signed   sa, sb, ss;
        longint unsigned ua, ub, prod;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        e_cout = 1'b0; e_ovf = 1'b0; e_inv = 1'b0; e_dz = 1'b0;
        case (op)
            4'h0: m_res = a & b;
            4'h1: m_res = a | b;
            4'hC: m_res = ~(a | b);
            4'h2: begin
                ss = sa + sb; m_res = a + b;
                e_cout = (ua + ub) > 64'hFFFF_FFFF;
                e_ovf  = (ss != longint'($signed(m_res)));
            end
            4'h3: begin
                m_res = a + b;
                e_cout = (ua + ub) > 64'hFFFF_FFFF;
                e_ovf  = e_cout;
            end
            4'h6: begin
                ss = sa - sb; m_res = a - b;
                e_cout = (ua >= ub);
                e_ovf  = (ss != longint'($signed(m_res)));
            end
            4'h4: m_res = (ua < ub) ? 32'd1 : 32'd0;
            4'h7: m_res = (sa < sb) ? 32'd1 : 32'd0;
            4'h8: begin
                prod = ua * ub;
                m_hi = prod[63:32]; m_lo = prod[31:0]; m_res = m_lo;
            end
            4'h9: begin
                if (b == 32'd0) e_dz = 1'b1;
                else begin m_lo = a / b; m_hi = a % b; m_res = m_lo; end
            end
            4'hA: m_res = m_hi;
            4'hB: m_res = m_lo;
            default: e_inv = 1'b1;
        endcase
    endtask

    task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus32.start = 1'b1; bus32.control = op; bus32.input_a = a; bus32.input_b = b;
        @(negedge clk);
        bus32.start = 1'b0;
    endtask

    task automatic test_reset();
        logic [102:0] got, want;
        rst = 1'b1;
        bus32.start = 1'b0; bus32.control = 4'h0; bus32.input_a = '0; bus32.input_b = '0;
        bus8.start  = 1'b0; bus8.control  = 4'h0; bus8.input_a  = '0; bus8.input_b  = '0;
        m_res = '0; m_hi = '0; m_lo = '0;
        e_cout = 1'b0; e_ovf = 1'b0; e_inv = 1'b0; e_dz = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        got = snap32(); want = want32(1'b0, 1'b1);
        checks++;
        if (got !== want) begin errors++; $display("FAIL reset32: got %h want %h", got, want); end
        checks++;
        if ({bus8.result, bus8.hi, bus8.lo, bus8.done, bus8.ready, bus8.zero} !== {24'd0, 3'b011}) begin
            errors++;
            $display("FAIL reset8: got %h want %h",
                     {bus8.result, bus8.hi, bus8.lo, bus8.done, bus8.ready, bus8.zero}, {24'd0, 3'b011});
        end
    endtask

    task automatic test_arith_corners();
        logic [3:0]  ops [6]  = '{4'h2, 4'h3, 4'h6, 4'h7, 4'h4, 4'h2};
        logic [31:0] as  [6]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
        logic [31:0] bs  [6]  = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd3};
        logic [31:0] kres[6]  = '{32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd5};
        logic [1:0]  kfl [6]  = '{2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
        logic [102:0] got, want;
        for (int i = 0; i < 6; i++) begin
            drive_op(ops[i], as[i], bs[i]);
            model_op(ops[i], as[i], bs[i]);
            got = snap32(); want = want32(1'b1, 1'b1);
            checks++;
            if (got !== want) begin errors++; $display("FAIL corner%0d: got %h want %h", i, got, want); end
            checks++;
            if ({bus32.result, bus32.cout, bus32.err_overflow} !== {kres[i], kfl[i]}) begin
                errors++;
                $display("FAIL corner%0d_const: got %h want %h", i,
                         {bus32.result, bus32.cout, bus32.err_overflow}, {kres[i], kfl[i]});
            end
        end
    endtask

    task automatic test_random_single(input int n);
        logic [3:0]  tbl [14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7,
                                  4'hA, 4'hB, 4'hC, 4'h9, 4'h5, 4'hD, 4'hF};
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [102:0] got, want;
        for (int i = 0; i < n; i++) begin
            op = tbl[$urandom_range(0, 13)];
            a  = rnd_opnd();
            b  = (op == 4'h9) ? 32'd0 : rnd_opnd();
            drive_op(op, a, b);
            model_op(op, a, b);
            got = snap32(); want = want32(1'b1, 1'b1);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL rand_single op=%h a=%h b=%h: got %h want %h", op, a, b, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [8];
        logic [31:0] as [8], bs [8];
        logic [3:0]  tbl [8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'hC};
        logic [102:0] got, want;
        for (int i = 0; i < 8; i++) begin
            ops[i] = tbl[$urandom_range(0, 7)]; as[i] = rnd_opnd(); bs[i] = rnd_opnd();
        end
        @(negedge clk);
        bus32.start = 1'b1; bus32.control = ops[0]; bus32.input_a = as[0]; bus32.input_b = bs[0];
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            model_op(ops[i], as[i], bs[i]);
            got = snap32(); want = want32(1'b1, 1'b1);
            checks++;
            if (got !== want) begin errors++; $display("FAIL b2b%0d: got %h want %h", i, got, want); end
            if (i < 7) begin
                bus32.control = ops[i+1]; bus32.input_a = as[i+1]; bus32.input_b = bs[i+1];
            end else begin
                bus32.start = 1'b0;
            end
        end
    endtask

    task automatic test_multicycle(input logic [3:0] op, input logic [31:0] opa, input logic [31:0] opb,
                                   input bit inject, input string name);
        int n;
        logic [31:0] prev_res;
        logic [102:0] got, want;
        prev_res = m_res;
        drive_op(op, opa, opb);
        checks++;
        if ({bus32.ready, bus32.done} !== 2'b00) begin
            errors++; $display("FAIL %s busy: got ready/done %b want 00", name, {bus32.ready, bus32.done});
        end
        n = 0;
        while (bus32.done !== 1'b1 && n < 3 * W) begin
            @(negedge clk);
            n++;
            if (inject && n == 3) begin
                bus32.start = 1'b1; bus32.control = 4'h2; bus32.input_a = 32'd1; bus32.input_b = 32'd1;
            end
            if (inject && n == 6) bus32.start = 1'b0;
            if (inject && n == 7) begin
                checks++;
                if ({bus32.ready, bus32.result} !== {1'b0, prev_res}) begin
                    errors++;
                    $display("FAIL %s ignore_start: got %h want %h", name,
                             {bus32.ready, bus32.result}, {1'b0, prev_res});
                end
            end
        end
        checks++;
        if (n != W) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, n, W); end
        model_op(op, opa, opb);
        got = snap32(); want = want32(1'b1, 1'b1);
        checks++;
        if (got !== want) begin errors++; $display("FAIL %s result: got %h want %h", name, got, want); end
    endtask

    task automatic test_multu();
        logic [102:0] got, want;
        test_multicycle(4'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "multu_max");
        checks++;
        if ({bus32.hi, bus32.lo} !== {32'hFFFF_FFFE, 32'h0000_0001}) begin
            errors++; $display("FAIL multu_const: got %h want %h", {bus32.hi, bus32.lo}, 64'hFFFF_FFFE_0000_0001);
        end
        // MFHI accepted on the edge where done falls
        bus32.start = 1'b1; bus32.control = 4'hA; bus32.input_a = '0; bus32.input_b = '0;
        @(negedge clk);
        bus32.start = 1'b0;
        model_op(4'hA, 32'd0, 32'd0);
        got = snap32(); want = want32(1'b1, 1'b1);
        checks++;
        if (got !== want || bus32.result !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL mfhi: got %h want %h", got, want);
        end
    endtask

    task automatic test_divu();
        logic [102:0] got, want;
        test_multicycle(4'h9, 32'd100, 32'd7, 1'b0, "divu_100_7");
        checks++;
        if ({bus32.hi, bus32.lo} !== {32'd2, 32'd14}) begin
            errors++; $display("FAIL divu_const: got %h want %h", {bus32.hi, bus32.lo}, {32'd2, 32'd14});
        end
        drive_op(4'h9, 32'd5, 32'd0);
        model_op(4'h9, 32'd5, 32'd0);
        got = snap32(); want = want32(1'b1, 1'b1);
        checks++;
        if (got !== want || {bus32.err_div_zero, bus32.hi, bus32.lo} !== {1'b1, 32'd2, 32'd14}) begin
            errors++; $display("FAIL divu_zero: got %h want %h", got, want);
        end
    endtask

    task automatic test_random_multicycle(input int n);
        logic [3:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < n; i++) begin
            op = ($urandom_range(0, 1) == 0) ? 4'h8 : 4'h9;
            a  = rnd_opnd();
            b  = rnd_opnd();
            if (op == 4'h9 && b == 32'd0) b = 32'($urandom_range(1, 1000));
            test_multicycle(op, a, b, 1'b0, (op == 4'h8) ? "rand_multu" : "rand_divu");
        end
    endtask

    task automatic test_invalid();
        logic [31:0] prev;
        logic [102:0] got, want;
        prev = m_res;
        drive_op(4'hF, 32'($urandom()), 32'($urandom()));
        model_op(4'hF, 32'd0, 32'd0);
        got = snap32(); want = want32(1'b1, 1'b1);
        checks++;
        if (got !== want || bus32.result !== prev || bus32.err_invalid_control !== 1'b1) begin
            errors++; $display("FAIL invalid: got %h want %h", got, want);
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [102:0] got, want;
        drive_op(4'h8, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        m_res = '0; m_hi = '0; m_lo = '0;
        e_cout = 1'b0; e_ovf = 1'b0; e_inv = 1'b0; e_dz = 1'b0;
        got = snap32(); want = want32(1'b0, 1'b1);
        checks++;
        if (got !== want) begin errors++; $display("FAIL reset_mid_mul: got %h want %h", got, want); end
        @(negedge clk);
        rst = 1'b0;
        drive_op(4'h2, 32'd2, 32'd3);
        model_op(4'h2, 32'd2, 32'd3);
        got = snap32(); want = want32(1'b1, 1'b1);
        checks++;
        if (got !== want || bus32.result !== 32'd5) begin
            errors++; $display("FAIL add_after_reset: got %h want %h", got, want);
        end
        @(negedge clk);
        checks++;
        if (bus32.done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b want 0", bus32.done); end
    endtask

    task automatic test_width8();
        int n;
        logic [7:0] a, b, ehi, elo;
        int unsigned prod;
        for (int i = 0; i < 5; i++) begin
            logic [3:0] op;
            op = (i == 0 || i == 2) ? 4'h8 : 4'h9;
            a  = (i == 0) ? 8'hFF : 8'($urandom());
            b  = (i == 0) ? 8'hFF : 8'($urandom_range(1, 255));
            if (op == 4'h8) begin
                prod = 32'(a) * 32'(b);
                ehi = prod[15:8]; elo = prod[7:0];
            end else begin
                ehi = a % b; elo = a / b;
            end
            @(negedge clk);
            bus8.start = 1'b1; bus8.control = op; bus8.input_a = a; bus8.input_b = b;
            @(negedge clk);
            bus8.start = 1'b0;
            n = 0;
            while (bus8.done !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n != 8) begin errors++; $display("FAIL w8_latency%0d: got %0d want 8", i, n); end
            checks++;
            if ({bus8.hi, bus8.lo, bus8.result, bus8.ready} !== {ehi, elo, elo, 1'b1}) begin
                errors++;
                $display("FAIL w8_op%0d op=%h a=%h b=%h: got %h want %h", i, op, a, b,
                         {bus8.hi, bus8.lo, bus8.result, bus8.ready}, {ehi, elo, elo, 1'b1});
            end
            @(negedge clk);
            checks++;
            if (bus8.done !== 1'b0) begin errors++; $display("FAIL w8_done_fall%0d: got %b want 0", i, bus8.done); end
        end
    endtask

    initial begin
        test_reset();
        test_arith_corners();
        test_random_single(60);
        test_back_to_back();
        test_multu();
        test_divu();
        test_random_multicycle(6);
        test_invalid();
        test_reset_mid_mul();
        test_width8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
